qdec_qp_fsm: RTL and testbench
==============================

# qdec_qp_fsm

Parametrised CABAC sub-FSM decoding the CU-level QP syntax group: `cu_qp_delta_abs` (context-coded TU prefix plus bypass EGk suffix), `cu_qp_delta_sign_flag` (bypass), `cu_chroma_qp_offset_flag` and `cu_chroma_qp_offset_idx` (TU, cMax = list length). It sits beside the other CU sub-FSMs under the CABAC main FSM. It drives the shared context-address / bin-decoder port with at most one bin outstanding. It returns decoded values plus a done interrupt.

## Interface
Parameters:
- ADDR_W, 10, context address width
- QPD_PREFIX_MAX, 5, cMax of the cu_qp_delta_abs TU prefix
- QPD_EGK, 0, Exp-Golomb order of the suffix
- EGK_MAX_ONES, 15, cap on suffix unary ones before error
- QPD_W, 8, signed width of decoded delta
- CQP_IDX_W, 3, width of chroma offset index

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- qp_start  in  1  one-cycle start pulse; ignored unless IDLE
- qpd_req  in  1  decode cu_qp_delta group (sampled at start)
- cqp_req  in  1  decode chroma offset group (sampled at start)
- chroma_qp_offset_list_len  in  3  TU cMax for idx (sampled at start)
- ctx_qp_addr  out  ADDR_W  context address of the next context bin
- ctx_qp_addr_vld  out  1  one-cycle context-fetch pulse
- dec_run_qp  out  1  one-cycle bin-decode request
- EPMode_qp  out  1  1 = bypass bin; valid while dec_run_qp is high
- dec_rdy  in  1  bin decoder can accept a request
- ruiBin  in  1  decoded bin
- ruiBin_vld  in  1  bin valid
- cu_qp_delta_val  out  QPD_W  signed CuQpDeltaVal
- cu_chroma_qp_offset_flag  out  1
- cu_chroma_qp_offset_idx  out  CQP_IDX_W
- qp_err  out  1  suffix exceeded EGK_MAX_ONES
- qp_done_intr  out  1  one-cycle done pulse

## Operation
- Shared package holds the state enum: IDLE_QP, QPD_PREFIX, QPD_SUFFIX, QPD_SIGN, CQP_FLAG, CQP_IDX, ENDING_QP.
- IDLE_QP + qp_start: go to QPD_PREFIX if qpd_req. Otherwise go to CQP_FLAG if cqp_req. Otherwise go to ENDING_QP. Clear all result registers and qp_err on start.
- QPD_PREFIX: bin 0 uses CTXIDX_CU_QP_DELTA_ABS[0]; later bins use [1]. A 0 bin stops the prefix, as does reaching QPD_PREFIX_MAX ones.
  - prefix == QPD_PREFIX_MAX: go to QPD_SUFFIX.
  - prefix > 0: go to QPD_SIGN.
  - prefix == 0: go to the chroma group or ENDING_QP.
- QPD_SUFFIX: all bins bypass, EGk decode.
  - Each 1 bin adds 1<<k, then k++.
  - A 0 bin ends the unary part; then read k LSB-first… no, MSB-first fixed bins.
  - If the ones count reaches EGK_MAX_ONES: set qp_err and go straight to ENDING_QP, skipping the remaining groups.
  - Next state is QPD_SIGN.
- QPD_SIGN: one bypass bin. abs = prefix + suffix. cu_qp_delta_val = sign ? -abs : abs, truncated to QPD_W.
- CQP_FLAG: one bin, context CTXIDX_CHROMA_QP_OFFSET_FLAG[0].
  - Go to CQP_IDX if flag && list_len > 0, else ENDING_QP.
- CQP_IDX: bins use context CTXIDX_CHROMA_QP_OFFSET_IDX[0]. Each 1 bin increments idx. Stop on a 0 bin or when idx == list_len.
- ENDING_QP: qp_done_intr = 1 for one cycle, then IDLE_QP. Results hold until the next qp_start.
- ruiBin_vld with no request outstanding is ignored. dec_rdy low stalls issue indefinitely.

## Timing
- Reset values: state IDLE_QP; all outputs and counters 0.
- Reset is asynchronous at any point, including mid-bin. The outstanding request is dropped.
- Context bin issue:
  - cycle T: ctx_qp_addr_vld=1 with ctx_qp_addr valid.
  - T+1: dec_run_qp=1, EPMode_qp=0.
  - Issue happens at the first cycle in which the state is active, dec_rdy=1 and no request is outstanding.
- Bypass bin issue: dec_run_qp=1 with EPMode_qp=1 in the issue cycle; no ctx_qp_addr_vld.
- A request is outstanding from dec_run_qp until ruiBin_vld. The next issue is at the earliest one cycle after ruiBin_vld.
- A state transition happens the cycle after the terminating ruiBin_vld.
- Empty decode (no group requested): qp_start at T gives ENDING_QP at T+1 and qp_done_intr at T+2.
- cu_qp_delta_val is valid at latest the cycle qp_done_intr is high.

## Structure
- Package `qdec_cabac_package` gets:
  - t_state_qp
  - CTXIDX_CU_QP_DELTA_ABS[0:1]; the chroma CTXIDX constants already exist there
- Sub-module `qdec_egk_bin_acc`: bypass EGk accumulator with start / bin_vld / bin / done / value / overflow, parametrised on k and EGK_MAX_ONES. Reusable by coeff_abs_level_remaining.

## Test plan
- qpd_req=1, bins 1,0 then sign 1 → three requests (ctx[0], ctx[1], bypass) → cu_qp_delta_val = -1, qp_done_intr once.
- qpd_req=1, prefix 1,1,1,1,1, suffix 1,1,0,1,0, sign 0 → suffix 5, cu_qp_delta_val = +10; the five suffix bins all have EPMode_qp=1.
- qpd_req=cqp_req=1, list_len=3: prefix 0 (no sign bin), flag 1, idx bins 1,1,1 → idx=3 after exactly 3 idx bins, delta 0.
- cqp_req only, flag 0 → no idx request, idx=0, flag=0; then list_len=0 with flag 1 → no idx request.
- Neither requested → done at T+2, zero dec_run_qp. Suffix of 15 ones → qp_err=1 and done without a sign bin.
- dec_rdy held low 10 cycles, spurious ruiBin_vld while idle, rst_n asserted mid-suffix → no issue while stalled, no state change, immediate IDLE_QP with outputs 0.

Source files
------------

// File: rtl/qdec_cabac_package.sv
// Shared CABAC definitions: sub-FSM state encodings and context index bases.
// Context constants are stored as packed tables so any sub-FSM can index them directly.
package qdec_cabac_package;

  typedef enum logic [2:0] {
    IDLE_QP,
    QPD_PREFIX,
    QPD_SUFFIX,
    QPD_SIGN,
    CQP_FLAG,
    CQP_IDX,
    ENDING_QP
  } t_state_qp;

  localparam logic [0:0][15:0] CTXIDX_CHROMA_QP_OFFSET_FLAG = {16'd164};
  localparam logic [0:0][15:0] CTXIDX_CHROMA_QP_OFFSET_IDX  = {16'd165};
  localparam logic [0:1][15:0] CTXIDX_CU_QP_DELTA_ABS       = {16'd156, 16'd157};

endpackage

// File: rtl/qdec_egk_bin_acc.sv
// Bypass-bin Exp-Golomb order-K accumulator: unary part, then K fixed bits MSB-first.
// done/value/overflow are combinational on the accepted bin so the caller can move on that cycle.
module qdec_egk_bin_acc #(
  parameter int K        = 0,
  parameter int MAX_ONES = 15,
  parameter int VAL_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bin_vld,
  input  logic             bin,
  output logic             done,
  output logic [VAL_W-1:0] value,
  output logic             overflow
);

  localparam int KW = $clog2(K + MAX_ONES + 1);
  localparam int OW = $clog2(MAX_ONES + 1);

  logic [VAL_W-1:0] acc_reg, acc_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [KW-1:0]    rem_reg, rem_next;
  logic [OW-1:0]    ones_reg, ones_next;
  logic             fixed_reg, fixed_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      k_reg     <= KW'(K);
      rem_reg   <= '0;
      ones_reg  <= '0;
      fixed_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      k_reg     <= k_next;
      rem_reg   <= rem_next;
      ones_reg  <= ones_next;
      fixed_reg <= fixed_next;
    end
  end

  always_comb begin
    acc_next   = acc_reg;
    k_next     = k_reg;
    rem_next   = rem_reg;
    ones_next  = ones_reg;
    fixed_next = fixed_reg;
    done       = 1'b0;
    overflow   = 1'b0;
    if (start) begin
      acc_next   = '0;
      k_next     = KW'(K);
      rem_next   = '0;
      ones_next  = '0;
      fixed_next = 1'b0;
    end else if (bin_vld) begin
      if (!fixed_reg) begin
        if (bin) begin
          acc_next  = acc_reg + (VAL_W'(1) << k_reg);
          k_next    = k_reg + 1'b1;
          ones_next = ones_reg + 1'b1;
          if (ones_reg == OW'(MAX_ONES - 1)) begin
            done     = 1'b1;
            overflow = 1'b1;
          end
        end else if (k_reg == '0) begin
          done = 1'b1;
        end else begin
          fixed_next = 1'b1;
          rem_next   = k_reg;
        end
      end else begin
        // fixed-length tail, first bin carries weight 2^(k-1)
        acc_next = acc_reg + (VAL_W'(bin) << (rem_reg - 1'b1));
        rem_next = rem_reg - 1'b1;
        if (rem_reg == KW'(1)) done = 1'b1;
      end
    end
  end

  assign value = acc_next;

endmodule

// File: rtl/qdec_qp_fsm.sv
// CABAC sub-FSM for the CU QP group: cu_qp_delta_abs/sign and chroma QP offset flag/idx.
// Drives the shared context/bin-decoder port with at most one bin outstanding.
module qdec_qp_fsm
  import qdec_cabac_package::*;
#(
  parameter int ADDR_W         = 10,
  parameter int QPD_PREFIX_MAX = 5,
  parameter int QPD_EGK        = 0,
  parameter int EGK_MAX_ONES   = 15,
  parameter int QPD_W          = 8,
  parameter int CQP_IDX_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 qp_start,
  input  logic                 qpd_req,
  input  logic                 cqp_req,
  input  logic [2:0]           chroma_qp_offset_list_len,
  output logic [ADDR_W-1:0]    ctx_qp_addr,
  output logic                 ctx_qp_addr_vld,
  output logic                 dec_run_qp,
  output logic                 EPMode_qp,
  input  logic                 dec_rdy,
  input  logic                 ruiBin,
  input  logic                 ruiBin_vld,
  output logic [QPD_W-1:0]     cu_qp_delta_val,
  output logic                 cu_chroma_qp_offset_flag,
  output logic [CQP_IDX_W-1:0] cu_chroma_qp_offset_idx,
  output logic                 qp_err,
  output logic                 qp_done_intr
);

  localparam int PW    = $clog2(QPD_PREFIX_MAX + 1);
  localparam int SUF_W = 32;

  t_state_qp            state_reg, state_next, after_qpd;
  logic                 run_ctx_reg, outst_reg, done_reg;
  logic                 cqp_req_reg;
  logic [2:0]           list_len_reg;
  logic [PW-1:0]        prefix_reg, prefix_next, prefix_inc;
  logic [CQP_IDX_W-1:0] idx_reg, idx_next, idx_inc;
  logic                 flag_reg, flag_next, err_reg, err_next;
  logic [QPD_W-1:0]     delta_reg, delta_next;
  logic                 is_ctx_state, is_byp_state, can_issue, bin_got, start_go;
  logic                 egk_done, egk_ovf;
  logic [SUF_W-1:0]     egk_value, abs_val;

  assign start_go = (state_reg == IDLE_QP) && qp_start;
  assign bin_got  = outst_reg && ruiBin_vld;

  qdec_egk_bin_acc #(
    .K        (QPD_EGK),
    .MAX_ONES (EGK_MAX_ONES),
    .VAL_W    (SUF_W)
  ) u_egk (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_go),
    .bin_vld  (bin_got && (state_reg == QPD_SUFFIX)),
    .bin      (ruiBin),
    .done     (egk_done),
    .value    (egk_value),
    .overflow (egk_ovf)
  );

  // A context bin reserves the port one cycle early (address fetch), so it counts as busy.
  always_comb begin
    is_ctx_state    = (state_reg == QPD_PREFIX) || (state_reg == CQP_FLAG) || (state_reg == CQP_IDX);
    is_byp_state    = (state_reg == QPD_SUFFIX) || (state_reg == QPD_SIGN);
    can_issue       = dec_rdy && !outst_reg && !run_ctx_reg;
    ctx_qp_addr_vld = is_ctx_state && can_issue;
    EPMode_qp       = is_byp_state && can_issue;
    dec_run_qp      = run_ctx_reg || EPMode_qp;
    ctx_qp_addr     = '0;
    case (state_reg)
      QPD_PREFIX: ctx_qp_addr = (prefix_reg == '0) ? ADDR_W'(CTXIDX_CU_QP_DELTA_ABS[0])
                                                   : ADDR_W'(CTXIDX_CU_QP_DELTA_ABS[1]);
      CQP_FLAG:   ctx_qp_addr = ADDR_W'(CTXIDX_CHROMA_QP_OFFSET_FLAG[0]);
      CQP_IDX:    ctx_qp_addr = ADDR_W'(CTXIDX_CHROMA_QP_OFFSET_IDX[0]);
      default:    ctx_qp_addr = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    prefix_next = prefix_reg;
    idx_next    = idx_reg;
    flag_next   = flag_reg;
    delta_next  = delta_reg;
    err_next    = err_reg;
    after_qpd   = cqp_req_reg ? CQP_FLAG : ENDING_QP;
    prefix_inc  = prefix_reg + 1'b1;
    idx_inc     = idx_reg + 1'b1;
    abs_val     = SUF_W'(prefix_reg) + egk_value;
    case (state_reg)
      IDLE_QP: if (qp_start) begin
        prefix_next = '0;
        idx_next    = '0;
        flag_next   = 1'b0;
        delta_next  = '0;
        err_next    = 1'b0;
        state_next  = qpd_req ? QPD_PREFIX : (cqp_req ? CQP_FLAG : ENDING_QP);
      end
      QPD_PREFIX: if (bin_got) begin
        if (ruiBin) begin
          prefix_next = prefix_inc;
          if (prefix_inc == PW'(QPD_PREFIX_MAX)) state_next = QPD_SUFFIX;
        end else begin
          state_next = (prefix_reg != '0) ? QPD_SIGN : after_qpd;
        end
      end
      QPD_SUFFIX: if (egk_done) begin
        err_next   = egk_ovf;
        state_next = egk_ovf ? ENDING_QP : QPD_SIGN;
      end
      QPD_SIGN: if (bin_got) begin
        delta_next = ruiBin ? QPD_W'(-abs_val) : QPD_W'(abs_val);
        state_next = after_qpd;
      end
      CQP_FLAG: if (bin_got) begin
        flag_next  = ruiBin;
        state_next = (ruiBin && list_len_reg != 3'd0) ? CQP_IDX : ENDING_QP;
      end
      CQP_IDX: if (bin_got) begin
        if (ruiBin) begin
          idx_next = idx_inc;
          if (idx_inc == CQP_IDX_W'(list_len_reg)) state_next = ENDING_QP;
        end else begin
          state_next = ENDING_QP;
        end
      end
      ENDING_QP: state_next = IDLE_QP;
      default:   state_next = IDLE_QP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE_QP;
      run_ctx_reg  <= 1'b0;
      outst_reg    <= 1'b0;
      done_reg     <= 1'b0;
      cqp_req_reg  <= 1'b0;
      list_len_reg <= '0;
      prefix_reg   <= '0;
      idx_reg      <= '0;
      flag_reg     <= 1'b0;
      delta_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_ctx_reg <= ctx_qp_addr_vld;
      if (dec_run_qp)   outst_reg <= 1'b1;
      else if (bin_got) outst_reg <= 1'b0;
      done_reg    <= (state_reg == ENDING_QP);
      if (start_go) begin
        cqp_req_reg  <= cqp_req;
        list_len_reg <= chroma_qp_offset_list_len;
      end
      prefix_reg  <= prefix_next;
      idx_reg     <= idx_next;
      flag_reg    <= flag_next;
      delta_reg   <= delta_next;
      err_reg     <= err_next;
    end
  end

  assign cu_qp_delta_val          = delta_reg;
  assign cu_chroma_qp_offset_flag = flag_reg;
  assign cu_chroma_qp_offset_idx  = idx_reg;
  assign qp_err                   = err_reg;
  assign qp_done_intr             = done_reg;

endmodule

// File: tb/tb_qdec_qp_fsm.sv
// Bench for qdec_qp_fsm: encodes chosen syntax values into expected bin requests,
// plays bin decoder with random latency/readiness, and checks requests and results.
module tb_qdec_qp_fsm;
  import qdec_cabac_package::*;

  localparam int ADDR_W = 10;
  localparam int QPD_W  = 8;
  localparam int CIW    = 3;
  localparam int PMAX   = 5;
  localparam int BUDGET = 800;

  logic              clk = 1'b0;
  logic              rst_n, qp_start, qpd_req, cqp_req, dec_rdy, ruiBin, ruiBin_vld;
  logic [2:0]        list_len;
  logic [ADDR_W-1:0] ctx_qp_addr;
  logic              ctx_qp_addr_vld, dec_run_qp, EPMode_qp, flag_o, qp_err, qp_done_intr;
  logic [QPD_W-1:0]  delta_o;
  logic [CIW-1:0]    idx_o;

  int checks = 0;
  int errors = 0;

  bit exp_byp[$];
  int exp_addr[$];
  bit exp_bin[$];
  int exp_delta, exp_flag, exp_idx, exp_err, n_exp;
  int A0, A1, FL, IX;

  always #5 clk = ~clk;

  qdec_qp_fsm #(
    .ADDR_W(ADDR_W), .QPD_PREFIX_MAX(PMAX), .QPD_EGK(0), .EGK_MAX_ONES(15),
    .QPD_W(QPD_W), .CQP_IDX_W(CIW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .qp_start(qp_start), .qpd_req(qpd_req), .cqp_req(cqp_req),
    .chroma_qp_offset_list_len(list_len), .ctx_qp_addr(ctx_qp_addr),
    .ctx_qp_addr_vld(ctx_qp_addr_vld), .dec_run_qp(dec_run_qp), .EPMode_qp(EPMode_qp),
    .dec_rdy(dec_rdy), .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
    .cu_qp_delta_val(delta_o), .cu_chroma_qp_offset_flag(flag_o),
    .cu_chroma_qp_offset_idx(idx_o), .qp_err(qp_err), .qp_done_intr(qp_done_intr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input bit byp, input int addr, input bit b);
    exp_byp.push_back(byp);
    exp_addr.push_back(addr);
    exp_bin.push_back(b);
  endtask

  task automatic clear_exp();
    exp_byp.delete(); exp_addr.delete(); exp_bin.delete();
    exp_delta = 0; exp_flag = 0; exp_idx = 0; exp_err = 0;
  endtask

  // Syntax values -> bin list: TU prefix, EG0 suffix, sign, then chroma flag and TU idx.
  task automatic enc_case(input bit qpd, input bit cqp, input int len, input int absv,
                          input bit sgn, input bit flg, input int idx);
    int pre, v, k;
    clear_exp();
    if (qpd) begin
      pre = (absv < PMAX) ? absv : PMAX;
      for (int i = 0; i < pre; i++) push(1'b0, (i == 0) ? A0 : A1, 1'b1);
      if (pre < PMAX) push(1'b0, (pre == 0) ? A0 : A1, 1'b0);
      if (absv >= PMAX) begin
        v = absv - PMAX;
        k = 0;
        while (v >= (1 << k)) begin
          v -= (1 << k);
          push(1'b1, 0, 1'b1);
          k++;
        end
        push(1'b1, 0, 1'b0);
        for (int i = k - 1; i >= 0; i--) push(1'b1, 0, ((v >> i) & 1) != 0);
      end
      if (absv > 0) begin
        push(1'b1, 0, sgn);
        exp_delta = sgn ? -absv : absv;
      end
    end
    if (cqp) begin
      push(1'b0, FL, flg);
      exp_flag = flg ? 1 : 0;
      if (flg && len > 0) begin
        for (int i = 0; i < idx; i++) push(1'b0, IX, 1'b1);
        if (idx < len) push(1'b0, IX, 1'b0);
        exp_idx = idx;
      end
    end
    n_exp = exp_byp.size();
  endtask

  task automatic enc_overflow();
    clear_exp();
    for (int i = 0; i < PMAX; i++) push(1'b0, (i == 0) ? A0 : A1, 1'b1);
    for (int i = 0; i < 15; i++) push(1'b1, 0, 1'b1);
    exp_err = 1;
    n_exp = exp_byp.size();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_run"},   32'(dec_run_qp), 32'd0);
    check({tag, "_avld"},  32'(ctx_qp_addr_vld), 32'd0);
    check({tag, "_done"},  32'(qp_done_intr), 32'd0);
    check({tag, "_delta"}, 32'(delta_o), 32'd0);
    check({tag, "_flag"},  32'(flag_o), 32'd0);
    check({tag, "_idx"},   32'(idx_o), 32'd0);
    check({tag, "_err"},   32'(qp_err), 32'd0);
  endtask

  task automatic run_case(input bit qpd, input bit cqp, input int len,
                          input int stall, input int abort_at);
    int  reqs, wait_cnt, done_cyc;
    bit  pend, pend_bin, ctx_prev, busy, fin, aborted, b, v;
    int  a;
    logic [ADDR_W-1:0] ctx_addr_prev;
    @(negedge clk);
    qpd_req = qpd; cqp_req = cqp; list_len = 3'(len); qp_start = 1'b1;
    reqs = 0; wait_cnt = 0; done_cyc = 0;
    pend = 0; pend_bin = 0; ctx_prev = 0; fin = 0; aborted = 0;
    ctx_addr_prev = '0;
    for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
      @(negedge clk);
      qp_start = 1'b0;
      ruiBin_vld = 1'b0;
      busy = pend;
      if (pend) begin
        if (wait_cnt == 0) begin
          ruiBin_vld = 1'b1;
          ruiBin = pend_bin;
          pend = 0;
        end else begin
          wait_cnt--;
        end
      end
      dec_rdy = (cyc <= stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      if (cyc <= stall) check("stall_quiet", 32'({ctx_qp_addr_vld, dec_run_qp}), 32'd0);
      if (dec_run_qp) begin
        reqs++;
        if (exp_byp.size() == 0) begin
          check("req_count", 32'(reqs), 32'(n_exp));
        end else begin
          b = exp_byp.pop_front();
          a = exp_addr.pop_front();
          v = exp_bin.pop_front();
          check("ep_mode", 32'(EPMode_qp), 32'(b));
          check("one_outstanding", 32'(busy), 32'd0);
          if (!b) begin
            check("ctx_vld_before_run", 32'(ctx_prev), 32'd1);
            check("ctx_addr", 32'(ctx_addr_prev), 32'(a));
          end
          pend = 1;
          pend_bin = v;
          wait_cnt = $urandom_range(0, 2);
          if (reqs == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_idle_zero("rst_mid");
            @(negedge clk);
            ruiBin_vld = 1'b0;
            #1;
            check_idle_zero("rst_hold");
            rst_n = 1'b1;
            aborted = 1;
            fin = 1;
          end
        end
      end
      ctx_prev = ctx_qp_addr_vld;
      ctx_addr_prev = ctx_qp_addr;
      if (!aborted && qp_done_intr) begin
        done_cyc = cyc;
        fin = 1;
      end
    end
    check("finished_in_budget", 32'(fin), 32'd1);
    if (!aborted) begin
      check("req_count", 32'(reqs), 32'(n_exp));
      check("delta", 32'($signed(delta_o)), 32'(exp_delta));
      check("flag", 32'(flag_o), 32'(exp_flag));
      check("idx", 32'(idx_o), 32'(exp_idx));
      check("err", 32'(qp_err), 32'(exp_err));
      if (n_exp == 0) check("empty_done_cycle", 32'(done_cyc), 32'd2);
      @(negedge clk);
      ruiBin_vld = 1'b0;
      #1;
      check("done_single_pulse", 32'(qp_done_intr), 32'd0);
      check("quiet_after_done", 32'(dec_run_qp), 32'd0);
    end
    $display("case qpd=%0d cqp=%0d len=%0d reqs=%0d delta=%0d flag=%0d idx=%0d err=%0d",
             qpd, cqp, len, reqs, $signed(delta_o), flag_o, idx_o, qp_err);
  endtask

  initial begin
    bit q, c, s, f;
    int len, av, ix;
    A0 = int'(CTXIDX_CU_QP_DELTA_ABS[0]);
    A1 = int'(CTXIDX_CU_QP_DELTA_ABS[1]);
    FL = int'(CTXIDX_CHROMA_QP_OFFSET_FLAG[0]);
    IX = int'(CTXIDX_CHROMA_QP_OFFSET_IDX[0]);
    rst_n = 1'b0; qp_start = 1'b0; qpd_req = 1'b0; cqp_req = 1'b0; list_len = 3'd0;
    dec_rdy = 1'b1; ruiBin = 1'b0; ruiBin_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    check("reset_addr", 32'(ctx_qp_addr), 32'd0);
    rst_n = 1'b1;

    // delta -1 with dec_rdy stalled for the first 10 cycles
    enc_case(1, 0, 0, 1, 1, 0, 0);  run_case(1, 0, 0, 10, -1);
    // full prefix plus suffix 5 -> +10
    enc_case(1, 0, 0, 10, 0, 0, 0); run_case(1, 0, 0, 0, -1);
    // delta 0 then idx reaching list_len without a terminating bin
    enc_case(1, 1, 3, 0, 0, 1, 3);  run_case(1, 1, 3, 0, -1);
    enc_case(0, 1, 3, 0, 0, 0, 0);  run_case(0, 1, 3, 0, -1);
    enc_case(0, 1, 0, 0, 0, 1, 0);  run_case(0, 1, 0, 0, -1);
    // nothing requested
    enc_case(0, 0, 0, 0, 0, 0, 0);  run_case(0, 0, 0, 0, -1);
    // suffix overflow skips sign and chroma group
    enc_overflow();                 run_case(1, 1, 3, 0, -1);

    // stray bin while idle must not start anything
    @(negedge clk);
    ruiBin_vld = 1'b1; ruiBin = 1'b1;
    @(negedge clk);
    ruiBin_vld = 1'b0;
    #1;
    check("spurious_run", 32'(dec_run_qp), 32'd0);
    check("spurious_done", 32'(qp_done_intr), 32'd0);

    // reset during the suffix, then a normal decode
    enc_case(1, 0, 0, 40, 1, 0, 0); run_case(1, 0, 0, 0, 7);
    enc_case(1, 1, 5, 7, 1, 1, 2);  run_case(1, 1, 5, 0, -1);

    for (int t = 0; t < 40; t++) begin
      q   = ($urandom_range(0, 1) == 1);
      c   = ($urandom_range(0, 1) == 1);
      s   = ($urandom_range(0, 1) == 1);
      f   = ($urandom_range(0, 1) == 1);
      len = int'($urandom_range(0, 7));
      av  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 120));
      ix  = int'($urandom_range(0, len));
      enc_case(q, c, len, av, s, f, ix);
      run_case(q, c, len, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
